afc_freq_comparator: RTL and testbench

AFC_FREQ_COMPARATOR -- requirements
Module: afc_freq_comparator

---
 rtl/afc_pkg.sv | 23 ++
 rtl/afc_sync_edge.sv | 32 +++
 rtl/afc_freq_comparator.sv | 188 ++++++++++++++++++
 tb/tb_afc_freq_comparator.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/afc_pkg.sv
// Shared definitions for the AFC calibration loop.
// Holds the comparator state encoding and the one-hot decision codes that the
// band-stepping FSM consumes on its comp_in input.
package afc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_MEASURE = 3'd2,
    ST_DECIDE  = 3'd3,
    ST_HOLD    = 3'd4
  } afc_state_e;

  localparam logic [2:0] COMP_NONE   = 3'b000;
  localparam logic [2:0] COMP_FAST   = 3'b100;
  localparam logic [2:0] COMP_SLOW   = 3'b010;
  localparam logic [2:0] COMP_FREEZE = 3'b001;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/afc_sync_edge.sv
// Brings the divided VCO into the clk domain and flags its rising edges.
// Ports:
//   clk, rst  - system clock, synchronous active-high reset
//   i_async   - asynchronous divided VCO input
//   o_rise    - one-cycle pulse per synchronized rising edge
module afc_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_rise
);

  logic r_s1;
  logic r_s2;
  logic r_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_d  <= 1'b0;
    end else begin
      r_s1 <= i_async;
      r_s2 <= r_s1;
      r_d  <= r_s2;
    end
  end

  // r_s2 is the first metastability-safe copy; r_d is its one-cycle delay.
  assign o_rise = r_s2 & ~r_d;

endmodule

// File: rtl/afc_freq_comparator.sv
// Frequency comparator for automatic frequency calibration.
// Counts divided-VCO rising edges over a fixed window after a settling delay
// and emits a one-hot fast/slow/freeze pulse for the band-stepping FSM.
// Ports:
//   clk, rst    - system clock, synchronous active-high reset
//   en          - calibration enable (level)
//   vco_div     - divided VCO, asynchronous to clk
//   tgt_count   - expected edges per window, latched at window start
//   comp_out    - one-hot decision pulse (100 fast, 010 slow, 001 freeze)
//   meas_count  - count of the last completed window
//   busy        - high while settling, measuring or deciding
//   done        - high while holding after a freeze decision
//   dbg_state   - current FSM state
//
// Handshake: there is no ready/valid pair; comp_out is a single-cycle strobe
// that the consumer must take in the cycle it is non-zero.
module afc_freq_comparator
  import afc_pkg::*;
#(
  parameter int WIN_CYCLES    = 1024,
  parameter int SETTLE_CYCLES = 64,
  parameter int CNT_W         = 12,
  parameter int TOL           = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             vco_div,
  input  logic [CNT_W-1:0] tgt_count,
  output logic [2:0]       comp_out,
  output logic [CNT_W-1:0] meas_count,
  output logic             busy,
  output logic             done,
  output afc_state_e       dbg_state
);

  localparam int TMR_W = $clog2(max_int(max_int(WIN_CYCLES, SETTLE_CYCLES), 2));
  localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] WIN_LOAD    = TMR_W'(WIN_CYCLES - 1);
  localparam logic [CNT_W:0]   TOL_EXT     = (CNT_W + 1)'(TOL);

  afc_state_e       r_state;
  afc_state_e       w_next_state;
  logic [TMR_W-1:0] r_timer;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_tgt;
  logic [CNT_W-1:0] r_meas;

  logic             w_edge;
  logic             w_timer_zero;
  logic             w_load_settle;
  logic             w_load_meas;
  logic             w_clear;
  logic [2:0]       w_comp;
  logic [2:0]       w_decision;
  logic [CNT_W:0]   w_count_ext;
  logic [CNT_W:0]   w_tgt_ext;
  logic [CNT_W:0]   w_hi;
  logic [CNT_W:0]   w_lo;

  afc_sync_edge u_sync_edge (
    .clk     (clk),
    .rst     (rst),
    .i_async (vco_div),
    .o_rise  (w_edge)
  );

  assign w_timer_zero = (r_timer == '0);

  // Bounds use one extra bit so tgt+TOL cannot wrap; the lower bound clamps at 0.
  always_comb begin
    w_count_ext = {1'b0, r_count};
    w_tgt_ext   = {1'b0, r_tgt};
    w_hi        = w_tgt_ext + TOL_EXT;
    w_lo        = (w_tgt_ext >= TOL_EXT) ? (w_tgt_ext - TOL_EXT) : '0;
    if (w_count_ext > w_hi) begin
      w_decision = COMP_FAST;
    end else if (w_count_ext < w_lo) begin
      w_decision = COMP_SLOW;
    end else begin
      w_decision = COMP_FREEZE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_load_settle = 1'b0;
    w_load_meas   = 1'b0;
    w_clear       = 1'b0;
    w_comp        = COMP_NONE;
    case (r_state)
      ST_IDLE: begin
        if (en) begin
          w_next_state  = ST_SETTLE;
          w_load_settle = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (!en) begin
          w_next_state = ST_IDLE;
          w_clear      = 1'b1;
        end else if (w_timer_zero) begin
          w_next_state = ST_MEASURE;
          w_load_meas  = 1'b1;
        end
      end
      ST_MEASURE: begin
        if (!en) begin
          w_next_state = ST_IDLE;
          w_clear      = 1'b1;
        end else if (w_timer_zero) begin
          w_next_state = ST_DECIDE;
        end
      end
      ST_DECIDE: begin
        // The pulse goes out even if en drops in this very cycle.
        w_comp = w_decision;
        if (!en) begin
          w_next_state = ST_IDLE;
          w_clear      = 1'b1;
        end else if (w_decision == COMP_FREEZE) begin
          w_next_state = ST_HOLD;
        end else begin
          w_next_state  = ST_SETTLE;
          w_load_settle = 1'b1;
        end
      end
      ST_HOLD: begin
        if (!en) begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer <= '0;
      r_count <= '0;
      r_tgt   <= '0;
      r_meas  <= '0;
    end else begin
      if (w_load_settle) begin
        r_timer <= SETTLE_LOAD;
      end else if (w_load_meas) begin
        r_timer <= WIN_LOAD;
      end else if (w_clear) begin
        r_timer <= '0;
      end else if (!w_timer_zero) begin
        r_timer <= r_timer - TMR_W'(1);
      end

      // Saturating edge count; only edges seen while in MEASURE are taken.
      if (w_load_meas || w_clear) begin
        r_count <= '0;
      end else if ((r_state == ST_MEASURE) && w_edge && (r_count != '1)) begin
        r_count <= r_count + CNT_W'(1);
      end

      if (w_load_meas) begin
        r_tgt <= tgt_count;
      end

      if (r_state == ST_DECIDE) begin
        r_meas <= r_count;
      end
    end
  end

  assign comp_out   = w_comp;
  assign meas_count = r_meas;
  assign busy       = (r_state == ST_SETTLE) || (r_state == ST_MEASURE) ||
                      (r_state == ST_DECIDE);
  assign done       = (r_state == ST_HOLD);
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_afc_freq_comparator.sv
module tb_afc_freq_comparator;
  import afc_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DUT A: default parameters, vco_div period 4 clk
  logic        rst_a, en_a, vco_a;
  logic [11:0] tgt_a;
  logic [2:0]  comp_a;
  logic [11:0] meas_a;
  logic        busy_a, done_a;
  afc_state_e  st_a;

  // DUT B: CNT_W=8, vco_div toggling every clk (period 2)
  logic        rst_b, en_b, vco_b;
  logic [7:0]  tgt_b;
  logic [2:0]  comp_b;
  logic [7:0]  meas_b;
  logic        busy_b, done_b;
  afc_state_e  st_b;

  afc_freq_comparator u_dut_a (
    .clk(clk), .rst(rst_a), .en(en_a), .vco_div(vco_a), .tgt_count(tgt_a),
    .comp_out(comp_a), .meas_count(meas_a), .busy(busy_a), .done(done_a),
    .dbg_state(st_a)
  );

  afc_freq_comparator #(.CNT_W(8)) u_dut_b (
    .clk(clk), .rst(rst_b), .en(en_b), .vco_div(vco_b), .tgt_count(tgt_b),
    .comp_out(comp_b), .meas_count(meas_b), .busy(busy_b), .done(done_b),
    .dbg_state(st_b)
  );

  // VCO stimulus, changed on the falling edge
  initial begin
    int ph;
    ph    = 0;
    vco_a = 1'b0;
    forever begin
      @(negedge clk);
      ph    = (ph + 1) % 4;
      vco_a = (ph < 2);
    end
  end

  initial begin
    vco_b = 1'b0;
    forever begin
      @(negedge clk);
      vco_b = ~vco_b;
    end
  end

  // ---------------- scoreboard ----------------
  int n_tests;
  int n_fail;
  logic [2:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every non-zero pulse on DUT A must match the next queued decision.
  always @(negedge clk) begin
    if (comp_a !== COMP_NONE) begin
      check("pulse_vs_queue", {29'd0, comp_a},
            (exp_q.size() > 0) ? {29'd0, exp_q.pop_front()} : 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // From IDLE: enable, run one full settle+measure, check the decision, drop en.
  task automatic run_case(input logic [11:0] tgt, input logic [2:0] exp, input string tag);
    tgt_a = tgt;
    en_a  = 1'b1;
    exp_q.push_back(exp);
    tick_n(1088);
    check({tag, "_pre"}, {29'd0, comp_a}, 32'd0);
    tick();
    check({tag, "_comp"}, {29'd0, comp_a}, {29'd0, exp});
    tick();
    check({tag, "_after"}, {29'd0, st_a},
          (exp == COMP_FREEZE) ? {29'd0, ST_HOLD} : {29'd0, ST_SETTLE});
    check({tag, "_meas"}, {20'd0, meas_a}, 32'd256);
    en_a = 1'b0;
    tick();
    check({tag, "_idle"}, {29'd0, st_a}, {29'd0, ST_IDLE});
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_a = 1'b1; en_a = 1'b0; tgt_a = '0;
    rst_b = 1'b1; en_b = 1'b0; tgt_b = '0;
    tick_n(3);

    // reset state
    check("rst_comp", {29'd0, comp_a}, 32'd0);
    check("rst_meas", {20'd0, meas_a}, 32'd0);
    check("rst_busy", {31'd0, busy_a}, 32'd0);
    check("rst_done", {31'd0, done_a}, 32'd0);
    check("rst_state", {29'd0, st_a}, {29'd0, ST_IDLE});
    rst_a = 1'b0;
    tick();

    // tgt=256: freeze after 64+1024 cycles, then HOLD
    tgt_a = 12'd256;
    en_a  = 1'b1;
    exp_q.push_back(COMP_FREEZE);
    tick();
    check("f_busy_settle", {31'd0, busy_a}, 32'd1);
    check("f_state_settle", {29'd0, st_a}, {29'd0, ST_SETTLE});
    tick_n(1087);
    check("f_pre_comp", {29'd0, comp_a}, 32'd0);
    tick();
    check("f_comp", {29'd0, comp_a}, {29'd0, COMP_FREEZE});
    check("f_busy_decide", {31'd0, busy_a}, 32'd1);
    tick();
    check("f_done", {31'd0, done_a}, 32'd1);
    check("f_meas", {20'd0, meas_a}, 32'd256);
    check("f_hold_comp", {29'd0, comp_a}, 32'd0);
    check("f_hold_busy", {31'd0, busy_a}, 32'd0);
    tick_n(5);
    check("f_hold_stays", {31'd0, done_a}, 32'd1);
    en_a = 1'b0;
    tick();
    check("f_idle", {29'd0, st_a}, {29'd0, ST_IDLE});
    check("f_idle_done", {31'd0, done_a}, 32'd0);

    // tgt=300: slow, loops back to SETTLE and repeats every 1089 cycles
    tgt_a = 12'd300;
    en_a  = 1'b1;
    exp_q.push_back(COMP_SLOW);
    exp_q.push_back(COMP_SLOW);
    tick_n(1089);
    check("s1_comp", {29'd0, comp_a}, {29'd0, COMP_SLOW});
    tick();
    check("s1_settle", {29'd0, st_a}, {29'd0, ST_SETTLE});
    check("s1_meas", {20'd0, meas_a}, 32'd256);
    tick_n(1087);
    check("s2_pre", {29'd0, comp_a}, 32'd0);
    tick();
    check("s2_comp", {29'd0, comp_a}, {29'd0, COMP_SLOW});
    en_a = 1'b0;
    tick();
    check("s2_idle", {29'd0, st_a}, {29'd0, ST_IDLE});

    // tolerance boundaries
    run_case(12'd200, COMP_FAST,   "tgt200");
    run_case(12'd258, COMP_FREEZE, "tgt258");
    run_case(12'd254, COMP_FREEZE, "tgt254");
    run_case(12'd259, COMP_SLOW,   "tgt259");

    // en dropped 500 cycles into MEASURE
    tgt_a = 12'd999;
    en_a  = 1'b1;
    tick_n(65);
    check("d_measure", {29'd0, st_a}, {29'd0, ST_MEASURE});
    tick_n(500);
    en_a = 1'b0;
    tick();
    check("d_idle", {29'd0, st_a}, {29'd0, ST_IDLE});
    check("d_meas_kept", {20'd0, meas_a}, 32'd256);
    tick_n(1200);
    check("d_still_idle", {29'd0, st_a}, {29'd0, ST_IDLE});

    // re-enable restarts from SETTLE; tgt change mid-window is ignored
    tgt_a = 12'd256;
    en_a  = 1'b1;
    exp_q.push_back(COMP_FREEZE);
    tick();
    check("r_settle", {29'd0, st_a}, {29'd0, ST_SETTLE});
    tick_n(164);
    tgt_a = 12'd100;
    tick_n(924);
    check("r_comp", {29'd0, comp_a}, {29'd0, COMP_FREEZE});
    tick();
    check("r_done", {31'd0, done_a}, 32'd1);
    en_a = 1'b0;
    tick();

    // DUT B: saturation at 255, then reset mid-window
    rst_b = 1'b0;
    tgt_b = 8'd200;
    en_b  = 1'b1;
    tick_n(1089);
    check("b_comp", {29'd0, comp_b}, {29'd0, COMP_FAST});
    tick();
    check("b_meas_sat", {24'd0, meas_b}, 32'd255);
    check("b_settle", {29'd0, st_b}, {29'd0, ST_SETTLE});
    tick_n(600);
    check("b_measure", {29'd0, st_b}, {29'd0, ST_MEASURE});
    rst_b = 1'b1;
    tick();
    check("b_rst_comp", {29'd0, comp_b}, 32'd0);
    check("b_rst_meas", {24'd0, meas_b}, 32'd0);
    check("b_rst_busy", {31'd0, busy_b}, 32'd0);
    check("b_rst_done", {31'd0, done_b}, 32'd0);
    check("b_rst_state", {29'd0, st_b}, {29'd0, ST_IDLE});
    rst_b = 1'b0;
    en_b  = 1'b0;
    tick_n(2);

    check("queue_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
